// File: rtl/mod_reduce_seq.sv
// rtl/mod_reduce_seq.sv - bit-serial restoring product-mod-modulus reducer (optional quotient: MOD_REDUCE_QUOT_EN)
module mod_reduce_seq #(
    parameter int RADIX = 78,
    parameter int MOD_W = 80
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*RADIX+1:0]   prod,
    input  logic [MOD_W-1:0]     modulus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MOD_W-1:0]     rem,
    output logic                 err
`ifdef MOD_REDUCE_QUOT_EN
    ,
    output logic [2*RADIX+1:0]   quot
`endif
);

    localparam int PW = 2*RADIX + 2;
    localparam int CW = $clog2(PW + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PW);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [PW-1:0]      r_p;
    logic [MOD_W-1:0]   r_m;
    // The partial remainder is always below M before each shift, so the
    // top bit of the MOD_W+1-bit R is identically zero and is not stored.
    logic [MOD_W-1:0]   r_r;
    logic [CW-1:0]      r_cnt;
    logic [MOD_W-1:0]   r_rem;
    logic               r_err;

    logic               w_accept;
    logic               w_mod_zero;
    logic               w_last;
    logic [MOD_W:0]     w_t;
    logic               w_ge;
    logic [MOD_W-1:0]   w_r_next;

    assign w_accept   = in_valid & in_ready;
    assign w_mod_zero = (modulus == '0);
    assign w_last     = (r_cnt == CNT_ONE);

    // One restoring step: shift the next product bit into the remainder
    // and subtract M when it fits. The difference fits in MOD_W bits.
    assign w_t      = {r_r, r_p[PW-1]};
    assign w_ge     = (w_t >= {1'b0, r_m});
    assign w_r_next = w_ge ? (w_t[MOD_W-1:0] - r_m) : w_t[MOD_W-1:0];

    assign rem = r_rem;
    assign err = r_err;

    // State register; reset forces IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the state.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = w_mod_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture on accept, one shift-subtract per RUN cycle, and the
    // result registers that hold the published remainder and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p   <= '0;
            r_m   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
            r_rem <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_p   <= prod;
            r_m   <= modulus;
            r_r   <= '0;
            r_cnt <= CNT_LOAD;
            if (w_mod_zero) begin
                r_rem <= '0;
                r_err <= 1'b1;
            end
        end else if (r_state == ST_RUN) begin
            r_r   <= w_r_next;
            r_p   <= {r_p[PW-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_ONE;
            if (w_last) begin
                r_rem <= w_r_next;
                r_err <= 1'b0;
            end
        end
    end

`ifdef MOD_REDUCE_QUOT_EN
    logic [PW-1:0] r_quot;

    assign quot = r_quot;

    // Quotient collects one compare outcome per RUN cycle, MSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quot <= '0;
        end else if (w_accept) begin
            r_quot <= '0;
        end else if (r_state == ST_RUN) begin
            r_quot <= {r_quot[PW-2:0], w_ge};
        end
    end
`endif

endmodule

// File: tb/tb_mod_reduce_seq.sv
// tb/tb_mod_reduce_seq.sv - directed self-checking bench for mod_reduce_seq
module tb_mod_reduce_seq;

    localparam int RADIX = 78;
    localparam int MW    = 80;
    localparam int PW    = 2*RADIX + 2;
    localparam int LIMIT = 400;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [PW-1:0]   prod;
    logic [MW-1:0]   modulus;
    logic            out_valid;
    logic            out_ready;
    logic [MW-1:0]   rem;
    logic            err;
`ifdef MOD_REDUCE_QUOT_EN
    logic [PW-1:0]   quot;
`endif

    int n_checks;
    int n_errors;

    mod_reduce_seq #(.RADIX(RADIX), .MOD_W(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .modulus   (modulus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rem       (rem),
        .err       (err)
`ifdef MOD_REDUCE_QUOT_EN
        ,
        .quot      (quot)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called 1 time unit after a rising edge with the DUT idle. Returns the
    // number of edges after the accept edge until out_valid is seen.
    task automatic offer(input logic [PW-1:0] p, input logic [MW-1:0] m, output int lat);
        prod     = p;
        modulus  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        prod     = {PW{1'b1}};
        modulus  = {MW{1'b1}};
        lat = 0;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        prod      = '0;
        modulus   = '0;
        #12;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (rem !== '0) begin n_errors++; $display("FAIL reset_rem: got %0d expected 0", rem); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", err); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL basic_in_ready_idle: got %b expected 1", in_ready); end
        offer(158'd100, 80'd7, lat);
        n_checks++; if (lat !== 158) begin n_errors++; $display("FAIL basic_latency: got %0d expected 158", lat); end
        n_checks++; if (rem !== 80'd2) begin n_errors++; $display("FAIL basic_rem: got %0d expected 2", rem); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL basic_err: got %b expected 0", err); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL basic_in_ready_done: got %b expected 0", in_ready); end
`ifdef MOD_REDUCE_QUOT_EN
        n_checks++; if (quot !== 158'd14) begin n_errors++; $display("FAIL basic_quot: got %0d expected 14", quot); end
`endif
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_out_valid_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_max();
        int lat;
        logic [MW-1:0] exp_rem;
        exp_rem = {2'b00, {78{1'b1}}};
        offer({PW{1'b1}}, {MW{1'b1}}, lat);
        n_checks++; if (lat !== 158) begin n_errors++; $display("FAIL max_latency: got %0d expected 158", lat); end
        n_checks++; if (rem !== exp_rem) begin n_errors++; $display("FAIL max_rem: got %h expected %h", rem, exp_rem); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL max_err: got %b expected 0", err); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        offer(158'd5, 80'd9, lat);
        n_checks++; if (rem !== 80'd5) begin n_errors++; $display("FAIL b2b_first_rem: got %0d expected 5", rem); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_in_ready_during_valid: got %b expected 0", in_ready); end
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_in_ready_after: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_out_valid_after: got %b expected 0", out_valid); end
        offer(158'd9, 80'd9, lat);
        n_checks++; if (lat !== 158) begin n_errors++; $display("FAIL b2b_second_latency: got %0d expected 158", lat); end
        n_checks++; if (rem !== 80'd0) begin n_errors++; $display("FAIL b2b_second_rem: got %0d expected 0", rem); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_mod();
        int lat;
        offer(158'd123, 80'd0, lat);
        n_checks++; if (lat !== 0) begin n_errors++; $display("FAIL zero_latency: got %0d expected 0", lat); end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL zero_out_valid: got %b expected 1", out_valid); end
        n_checks++; if (rem !== 80'd0) begin n_errors++; $display("FAIL zero_rem: got %0d expected 0", rem); end
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL zero_err: got %b expected 1", err); end
`ifdef MOD_REDUCE_QUOT_EN
        n_checks++; if (quot !== '0) begin n_errors++; $display("FAIL zero_quot: got %0d expected 0", quot); end
`endif
        @(posedge clk);
        #1;
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL zero_err_hold_idle: got %b expected 1", err); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL zero_in_ready_after: got %b expected 1", in_ready); end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        offer(158'd100, 80'd7, lat);
        n_checks++; if (lat !== 158) begin n_errors++; $display("FAIL bp_latency: got %0d expected 158", lat); end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                prod     = 158'd5;
                modulus  = 80'd9;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_out_valid_hold[%0d]: got %b expected 1", i, out_valid); end
            n_checks++; if (rem !== 80'd2) begin n_errors++; $display("FAIL bp_rem_hold[%0d]: got %0d expected 2", i, rem); end
            n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready_hold[%0d]: got %b expected 0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_out_valid_drop: got %b expected 0", out_valid); end
        n_checks++; if (rem !== 80'd2) begin n_errors++; $display("FAIL bp_rem_idle_hold: got %0d expected 2", rem); end
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_no_ghost_job: got in_ready %b expected 1", in_ready); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        prod     = 158'd100;
        modulus  = 80'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rstrun_busy: got in_ready %b expected 0", in_ready); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstrun_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (rem !== 80'd0) begin n_errors++; $display("FAIL rstrun_rem: got %0d expected 0", rem); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rstrun_err: got %b expected 0", err); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rstrun_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        offer(158'd100, 80'd7, lat);
        n_checks++; if (lat !== 158) begin n_errors++; $display("FAIL rstrun_fresh_latency: got %0d expected 158", lat); end
        n_checks++; if (rem !== 80'd2) begin n_errors++; $display("FAIL rstrun_fresh_rem: got %0d expected 2", rem); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_max();
        test_back_to_back();
        test_zero_mod();
        test_backpressure();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mod_reduce_seq.md
Name: mod_reduce_seq

Overview:
- Downstream stage of the 80-bit middle-bits multiplier.
- Accepts its 2*RADIX+2-bit product plus a modulus and computes product mod modulus by bit-serial restoring shift-subtract, one product bit per clock.
- Valid/ready on both sides, so the multiplier controller can drop a product in and the consumer can stall the remainder.

Parameters:
- RADIX, 78, product width is 2*RADIX+2 (158 bits by default).
- MOD_W, 80, modulus and remainder width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  product/modulus offered.
- in_ready  out  1  block can accept; high only in IDLE.
- prod  in  2*RADIX+2  product from the multiplier.
- modulus  in  MOD_W  modulus m, unsigned.
- out_valid  out  1  remainder valid; held until taken.
- out_ready  in  1  consumer accepts remainder.
- rem  out  MOD_W  prod mod m.
- err  out  1  high with out_valid when m was 0.

Behaviour:
- Reset: rst high clears asynchronously, regardless of state (including mid-RUN). Effects:
  - state=IDLE.
  - out_valid=0, rem=0, err=0.
  - internal regs cleared.
  - in_ready=1 as soon as reset asserts.
- States and transitions:
  - IDLE -> RUN: on in_valid&in_ready with m!=0.
  - IDLE -> DONE: on in_valid&in_ready with m==0.
  - RUN -> DONE: on the edge performing the last iteration.
  - DONE -> IDLE: on out_valid&out_ready.
- Accept edge:
  - Latch prod into shift reg P and m into M.
  - Clear remainder reg R (MOD_W+1 bits).
  - Load bit counter with 2*RADIX+2.
- Each RUN edge:
  - T = {R[MOD_W-1:0], P[msb]}.
  - If T>=M then R=T-M, else R=T.
  - P shifts left 1; counter decrements.
  - Compares/subtracts are unsigned at MOD_W+1 bits; no overflow because R<M always holds before the shift.
- Latency:
  - m!=0: out_valid rises exactly 2*RADIX+2 edges after the accept edge (158 by default).
  - m==0: out_valid rises on the next edge, with rem=0 and err=1.
- DONE:
  - out_valid=1; rem=R[MOD_W-1:0] and err stay stable while out_ready=0.
  - in_ready=0; in_valid is ignored.
- Output handshake:
  - On out_valid&out_ready: out_valid drops next edge and state returns to IDLE.
  - in_ready rises the cycle after the handshake; no same-cycle turnaround.
  - rem and err hold their last values in IDLE until the next result.
- in_valid while not in IDLE: ignored; the upstream must hold it. prod/modulus are sampled only on the accept edge.
- prod < m: result equals prod, with no special-case path.

Optional Feature:
- Macro: MOD_REDUCE_QUOT_EN.
- Defined:
  - Adds output port quot, width 2*RADIX+2.
  - quot shifts in 1 when T>=M, else 0, each RUN edge.
  - quot is valid with out_valid, cleared on reset and on accept, and is 0 when err=1.
- Undefined: no quot port and no quotient register; all other behaviour is identical.

Test Plan:
- prod=100, m=7, out_ready=1 -> out_valid exactly 158 edges after accept, rem=2, err=0; with MOD_REDUCE_QUOT_EN, quot=14.
- prod=2^158-1, m=2^80-1 -> rem=2^78-1, err=0.
- prod=5, m=9 -> rem=5. Then back-to-back: prod=9, m=9 -> rem=0; in_ready rises one cycle after the first out handshake.
- m=0, prod=123 -> out_valid one edge after accept, rem=0, err=1; quot=0 if enabled.
- Backpressure: prod=100, m=7, out_ready=0 for 10 cycles after out_valid -> out_valid, rem=2 and in_ready=0 held stable throughout. A new in_valid pulse during the stall is ignored.
- rst pulsed 50 cycles into RUN -> out_valid=0, rem=0, err=0 and in_ready=1 immediately. A fresh prod=100, m=7 afterwards yields rem=2 after 158 edges.
